// File: rtl/serial_rx_scheduler.sv
// serial_rx_scheduler: round-robin arbiter for NUM_CH serial requesters.
// A granted channel shifts in DATA_WIDTH bits, LSB first, and the assembled
// word is presented on a valid/ready output port tagged with its channel.
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   req, sdata     : per-channel request (held for the whole word) and serial data
//   gnt            : registered one-hot grant
//   out_data/ch    : assembled word and source channel, qualified by out_valid
//   out_ready      : consumer accept
//   busy           : high whenever the scheduler is not idle
module serial_rx_scheduler #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         sdata,
    output logic [NUM_CH-1:0]         gnt,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int unsigned CW   = $clog2(NUM_CH);
    localparam int unsigned CNTW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         last_ch_q;   // doubles as the active channel select
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CNTW-1:0]       cnt_q;

    logic                  pick_valid;
    logic [CW-1:0]         pick_ch;
    logic [CW-1:0]         cand;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  cnt_done;
    logic                  out_free;

    // Round-robin search upward from last_ch+1, wrapping through last_ch itself.
    always_comb begin
        pick_valid = 1'b0;
        pick_ch    = last_ch_q;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = CW'(32'(last_ch_q) + i);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    // New bit enters at the MSB so the first sampled bit ends up in bit 0.
    assign shift_d  = {sdata[last_ch_q], shreg_q[DATA_WIDTH-1:1]};
    assign cnt_done = (cnt_q == CNTW'(DATA_WIDTH - 1));
    assign out_free = !out_valid || out_ready;

    // Scheduler state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            last_ch_q <= CW'(NUM_CH - 1);
            shreg_q   <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Accepted word retires unless a new word is loaded below.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q   <= ST_SHIFT;
                        last_ch_q <= pick_ch;
                        gnt       <= NUM_CH'(1) << pick_ch;
                        cnt_q     <= '0;
                        busy      <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (!req[last_ch_q]) begin
                        // Requester withdrew: drop the partial word silently.
                        state_q <= ST_IDLE;
                        gnt     <= '0;
                        cnt_q   <= '0;
                        shreg_q <= '0;
                        busy    <= 1'b0;
                    end else begin
                        shreg_q <= shift_d;
                        if (cnt_done) begin
                            gnt   <= '0;
                            cnt_q <= '0;
                            if (out_free) begin
                                out_data  <= shift_d;
                                out_ch    <= last_ch_q;
                                out_valid <= 1'b1;
                                state_q   <= ST_IDLE;
                                busy      <= 1'b0;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNTW'(1);
                        end
                    end
                end

                ST_HOLD: begin
                    if (out_ready) begin
                        out_data  <= shreg_q;
                        out_ch    <= last_ch_q;
                        out_valid <= 1'b1;
                        state_q   <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    gnt     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_scheduler.sv
// Testbench for serial_rx_scheduler: directed sequence with a scoreboard of
// expected {channel, word} entries consumed by an output monitor.
module tb_serial_rx_scheduler;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] sdata = '0;
    logic [3:0] gnt;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] tx_word [4];
    int         bit_idx [4] = '{default: 0};
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic [1:0] prev_ch    = '0;

    serial_rx_scheduler #(
        .DATA_WIDTH(8),
        .NUM_CH    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .sdata    (sdata),
        .gnt      (gnt),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial source: feeds the granted channel LSB first, noise elsewhere.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 4; c++) begin
            if (gnt[c]) begin
                sdata[c]   = tx_word[c][3'(bit_idx[c])];
                bit_idx[c] = bit_idx[c] + 1;
            end else begin
                sdata[c]   = 1'($urandom_range(1, 0));
                bit_idx[c] = 0;
            end
        end
    end

    // Output monitor: sampled late in the cycle so out_ready matches what the next edge sees.
    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'(1));
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_ch", 32'(out_ch), 32'(prev_ch));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_ch", 32'(out_ch), 32'(mon_e.ch));
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ch    = out_ch;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Wait (bounded) for a grant, then compare it.
    task automatic wait_gnt(input string tag, input logic [3:0] exp_gnt);
        for (int i = 0; i < 6 && gnt == '0; i++) @(negedge clk);
        check(tag, 32'(gnt), 32'(exp_gnt));
    endtask

    // Count consecutive negedges with gnt == g; ends on the first negedge it differs.
    task automatic count_gnt(input string tag, input logic [3:0] g, input int already, input int exp_n);
        int n;
        n = already;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != g) break;
            n++;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        out_ready = 1'b1;
        tx_word   = '{8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        check("rst_ch", 32'(out_ch), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        #1 reset = 1'b1;
        @(negedge clk);
        check("idle_gnt", 32'(gnt), 32'(0));

        // Single word on channel 2: bits 1,0,1,1,0,0,1,0 -> 8'h4D
        tx_word[2] = 8'h4D;
        exp_q.push_back('{ch: 2'd2, data: 8'h4D});
        #1 req = 4'b0100;
        wait_gnt("t1_gnt", 4'b0100);
        check("t1_busy", 32'(busy), 32'(1));
        count_gnt("t1_len", 4'b0100, 1, 8);
        check("t1_valid", 32'(out_valid), 32'(1));
        #1 req = '0;
        @(negedge clk);
        check("t1_pulse", 32'(out_valid), 32'(0));
        check("t1_idle", 32'(busy), 32'(0));

        // Fairness from reset: order 0,1,2,3,0
        #1 do_reset();
        tx_word = '{8'h3C, 8'hA5, 8'h96, 8'hE1};
        for (int k = 0; k < 5; k++) exp_q.push_back('{ch: 2'(k % 4), data: tx_word[k % 4]});
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt($sformatf("t2_gnt%0d", k), 4'(32'(1) << (k % 4)));
            count_gnt($sformatf("t2_len%0d", k), 4'(32'(1) << (k % 4)), 1, 8);
        end
        #1 req = '0;
        repeat (2) @(negedge clk);
        check("t2_drain", 32'(exp_q.size()), 32'(0));

        // Backpressure: second word completes while the first is unaccepted
        tx_word[1] = 8'h5A;
        tx_word[2] = 8'hC3;
        exp_q.push_back('{ch: 2'd1, data: 8'h5A});
        exp_q.push_back('{ch: 2'd2, data: 8'hC3});
        #1 out_ready = 1'b0;
        req = 4'b0110;
        wait_gnt("t3_gnt1", 4'b0010);
        count_gnt("t3_len1", 4'b0010, 1, 8);
        check("t3_first", 32'(out_data), 32'(8'h5A));
        wait_gnt("t3_gnt2", 4'b0100);
        count_gnt("t3_len2", 4'b0100, 1, 8);
        check("t3_hold_busy", 32'(busy), 32'(1));
        check("t3_hold_data", 32'(out_data), 32'(8'h5A));
        check("t3_hold_ch", 32'(out_ch), 32'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_gnt", 32'(gnt), 32'(0));
        end
        #1 req = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_second_valid", 32'(out_valid), 32'(1));
        check("t3_second_data", 32'(out_data), 32'(8'hC3));
        check("t3_second_ch", 32'(out_ch), 32'(2));
        @(negedge clk);
        check("t3_done_valid", 32'(out_valid), 32'(0));
        check("t3_done_busy", 32'(busy), 32'(0));

        // Abort: channel 1 drops after 3 bits, channel 2 takes the next grant
        tx_word[1] = 8'hFF;
        tx_word[2] = 8'h81;
        exp_q.push_back('{ch: 2'd2, data: 8'h81});
        #1 req = 4'b0110;
        wait_gnt("t4_gnt1", 4'b0010);
        repeat (3) @(negedge clk);
        check("t4_mid_gnt", 32'(gnt), 32'(4'b0010));
        #1 req = 4'b0100;
        @(negedge clk);
        check("t4_abort_gnt", 32'(gnt), 32'(0));
        check("t4_abort_valid", 32'(out_valid), 32'(0));
        check("t4_abort_busy", 32'(busy), 32'(0));
        wait_gnt("t4_gnt2", 4'b0100);
        count_gnt("t4_len2", 4'b0100, 1, 8);
        check("t4_valid", 32'(out_valid), 32'(1));
        #1 req = '0;
        @(negedge clk);
        check("t4_pulse", 32'(out_valid), 32'(0));
        check("t4_drain", 32'(exp_q.size()), 32'(0));

        // Reset after 5 bits of a channel-3 word
        tx_word[3] = 8'h96;
        #1 req = 4'b1000;
        wait_gnt("t5_gnt", 4'b1000);
        repeat (5) @(negedge clk);
        check("t5_mid_gnt", 32'(gnt), 32'(4'b1000));
        #1 reset = 1'b0;
        #1;
        check("t5_rst_gnt", 32'(gnt), 32'(0));
        check("t5_rst_valid", 32'(out_valid), 32'(0));
        check("t5_rst_data", 32'(out_data), 32'(0));
        check("t5_rst_ch", 32'(out_ch), 32'(0));
        check("t5_rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        #1 reset = 1'b1;
        wait_gnt("t5_regnt", 4'b1000);
        check("t5_no_early_valid", 32'(out_valid), 32'(0));
        exp_q.push_back('{ch: 2'd3, data: 8'h96});
        count_gnt("t5_len", 4'b1000, 1, 8);
        check("t5_valid", 32'(out_valid), 32'(1));
        #1 req = '0;
        repeat (2) @(negedge clk);
        check("t5_drain", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
